// File: rtl/spi_reg_responder.sv
// SPI mode-0 slave giving command/register access to a 32x8 register file, plus a local fabric port.
// Optional feature: define SPI_REG_RESPONDER_AUTOINC_EN to step the address after every data byte.
module spi_reg_responder #(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [7:0]  RESET_STATUS = 8'h00
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       spi_SCLK,
  input  logic       spi_MOSI,
  input  logic       spi_SS_n,
  output logic       spi_MISO,
  output logic       spi_MISO_oe,
  input  logic [7:0] status_in,
  input  logic [4:0] loc_addr,
  input  logic       loc_we,
  input  logic [7:0] loc_wdata,
  output logic [7:0] loc_rdata,
  output logic       spi_wr_stb,
  output logic [4:0] spi_wr_addr
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
  logic                   sclk_prev_q, ss_prev_q;
  logic                   sclk_s, mosi_s, ss_s;
  logic                   ss_fall, ss_rise, rise_act, fall_act, byte_done;
  logic                   in_xfer, in_cmd;
  logic [2:0]             bit_cnt_q;
  logic [6:0]             rx_shift_q;
  logic [7:0]             rx_byte;
  logic [7:0]             tx_shift_q;
  logic                   skip_fall_q;
  logic [4:0]             addr_q, reload_addr;
  logic                   dir_q, reload_wr;
  logic [7:0]             reload_val;
  logic                   spi_we;
  logic                   oe_q, wr_stb_q;
  logic [4:0]             wr_addr_q;
  logic [7:0]             loc_rdata_q;
  logic [7:0]             regfile_q [32];

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_MOSI};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_SS_n};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
    end
  end

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s    = ss_sync_q[SYNC_STAGES-1];
  assign ss_fall = ss_prev_q & ~ss_s;
  assign ss_rise = ~ss_prev_q & ss_s;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ss_fall) state_d = ST_CMD;
      ST_CMD: begin
        if (ss_rise)        state_d = ST_IDLE;
        else if (byte_done) state_d = ST_DATA;
      end
      ST_DATA: if (ss_rise) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_xfer = (state_q != ST_IDLE);
    in_cmd  = (state_q == ST_CMD);
  end

  // A high SS_n masks SCLK edges even before the state machine has left the transaction.
  assign rise_act  = sclk_s & ~sclk_prev_q & ~ss_s & in_xfer;
  assign fall_act  = ~sclk_s & sclk_prev_q & ~ss_s & in_xfer;
  assign byte_done = rise_act & (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_shift_q, mosi_s};
  assign spi_we    = byte_done & ~in_cmd & dir_q;

  always_comb begin
    if (in_cmd) begin
      reload_addr = rx_byte[7:3];
      reload_wr   = rx_byte[1];
    end else begin
`ifdef SPI_REG_RESPONDER_AUTOINC_EN
      reload_addr = addr_q + 5'd1;
`else
      reload_addr = addr_q;
`endif
      reload_wr   = dir_q;
    end
    reload_val = reload_wr ? 8'h00 : regfile_q[reload_addr];
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= RESET_STATUS;
      skip_fall_q <= 1'b0;
      addr_q      <= '0;
      dir_q       <= 1'b0;
      oe_q        <= 1'b0;
    end else if (ss_fall) begin
      tx_shift_q  <= status_in;
      bit_cnt_q   <= '0;
      skip_fall_q <= 1'b0;
      oe_q        <= 1'b1;
    end else if (ss_rise) begin
      tx_shift_q  <= RESET_STATUS;
      bit_cnt_q   <= '0;
      skip_fall_q <= 1'b0;
      oe_q        <= 1'b0;
    end else if (rise_act) begin
      rx_shift_q <= rx_byte[6:0];
      bit_cnt_q  <= bit_cnt_q + 3'd1;
      if (byte_done) begin
        addr_q      <= reload_addr;
        dir_q       <= reload_wr;
        tx_shift_q  <= reload_val;
        skip_fall_q <= 1'b1;
      end
    end else if (fall_act) begin
      // The fall right after a byte boundary keeps the freshly loaded MSB on the wire.
      if (skip_fall_q) skip_fall_q <= 1'b0;
      else             tx_shift_q  <= {tx_shift_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      wr_stb_q <= spi_we;
      if (spi_we) wr_addr_q <= addr_q;
    end
  end

  // SPI write is applied last so it wins a same-address collision with the local port.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < 32; i++) regfile_q[i] <= '0;
      loc_rdata_q <= '0;
    end else begin
      if (loc_we) regfile_q[loc_addr] <= loc_wdata;
      if (spi_we) regfile_q[addr_q]   <= rx_byte;
      loc_rdata_q <= regfile_q[loc_addr];
    end
  end

  assign spi_MISO    = tx_shift_q[7];
  assign spi_MISO_oe = oe_q;
  assign loc_rdata   = loc_rdata_q;
  assign spi_wr_stb  = wr_stb_q;
  assign spi_wr_addr = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Bench for spi_reg_responder: directed vector table, hand-built corner sequences and
// randomized transactions checked against a register-array reference model.
module tb_spi_reg_responder;

`ifdef SPI_REG_RESPONDER_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_SCLK, spi_MOSI, spi_SS_n;
  logic       spi_MISO, spi_MISO_oe;
  logic [7:0] status_in;
  logic [4:0] loc_addr;
  logic       loc_we;
  logic [7:0] loc_wdata;
  logic [7:0] loc_rdata;
  logic       spi_wr_stb;
  logic [4:0] spi_wr_addr;

  spi_reg_responder dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .spi_SCLK    (spi_SCLK),
    .spi_MOSI    (spi_MOSI),
    .spi_SS_n    (spi_SS_n),
    .spi_MISO    (spi_MISO),
    .spi_MISO_oe (spi_MISO_oe),
    .status_in   (status_in),
    .loc_addr    (loc_addr),
    .loc_we      (loc_we),
    .loc_wdata   (loc_wdata),
    .loc_rdata   (loc_rdata),
    .spi_wr_stb  (spi_wr_stb),
    .spi_wr_addr (spi_wr_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] status;
    logic [7:0] cmd;
    logic [7:0] d0;
    logic [7:0] d1;
    int         ndata;
    int         abort_bits;
    logic [7:0] exp_b0;
    logic [7:0] exp_last;
    logic [4:0] chk_addr;
    logic [7:0] exp_reg;
    int         exp_stb;
    logic [4:0] exp_stb_addr;
  } vec_t;

  vec_t       vt [8];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         stb_cnt = 0;
  logic [4:0] stb_last = '0;

  logic [7:0] tx_b [4];
  logic [7:0] rx_b [4];
  int         nbytes, abort_bits;
  logic [7:0] abort_byte;
  int         col_byte = -1;
  int         col_bit  = 0;
  logic [4:0] col_addr;
  logic [7:0] col_data;

  logic [7:0] mrf [32];
  logic [7:0] exp_rx [4];
  int         exp_stb;
  logic [4:0] exp_stb_addr;

  always @(negedge clk) begin
    if (spi_wr_stb === 1'b1) begin
      stb_cnt++;
      stb_last = spi_wr_addr;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each data byte targets cmd address (+k when autoinc), writes land, reads see current contents.
  task automatic model_xfer(input logic [7:0] status);
    logic [4:0] a, ea;
    a = tx_b[0][7:3];
    exp_rx[0] = status;
    exp_stb = 0;
    exp_stb_addr = '0;
    for (int k = 1; k < nbytes; k++) begin
      ea = AI ? a + 5'(k - 1) : a;
      if (tx_b[0][1]) begin
        exp_rx[k] = 8'h00;
        mrf[ea] = tx_b[k];
        exp_stb++;
        exp_stb_addr = ea;
      end else begin
        exp_rx[k] = mrf[ea];
      end
    end
  endtask

  task automatic spi_byte(input int idx, input logic [7:0] b, input int nbits);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_MOSI = b[i];
      repeat (8) @(negedge clk);
      r[i] = spi_MISO;
      spi_SCLK = 1'b1;
      if (idx == col_byte && i == col_bit) begin
        // local write lands on the same clk edge the synchronized rise is acted on
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        loc_addr = col_addr; loc_wdata = col_data; loc_we = 1'b1;
        @(negedge clk);
        loc_we = 1'b0;
        repeat (6) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      spi_SCLK = 1'b0;
    end
    if (idx < 4) rx_b[idx] = r;
  endtask

  task automatic spi_xfer();
    spi_SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < nbytes; k++) spi_byte(k, tx_b[k], 8);
    if (abort_bits > 0) spi_byte(nbytes, abort_byte, abort_bits);
    repeat (8) @(negedge clk);
    chk("oe_active", spi_MISO_oe, 1'b1);
    spi_SS_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("oe_idle", spi_MISO_oe, 1'b0);
  endtask

  task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    loc_addr = a; loc_wdata = d; loc_we = 1'b1;
    @(negedge clk);
    loc_we = 1'b0;
    mrf[a] = d;
  endtask

  task automatic loc_read(input logic [4:0] a, output logic [7:0] d);
    @(negedge clk);
    loc_addr = a;
    @(negedge clk);
    d = loc_rdata;
  endtask

  task automatic run_xfer(input logic [7:0] st, input logic [7:0] c, input logic [7:0] a0,
                          input logic [7:0] a1, input logic [7:0] a2, input int nd, input int ab);
    status_in = st;
    tx_b[0] = c; tx_b[1] = a0; tx_b[2] = a1; tx_b[3] = a2;
    nbytes = 1 + nd;
    abort_bits = ab;
    model_xfer(st);
    spi_xfer();
  endtask

  initial begin
    logic [7:0] rd;
    int s0;
    logic [7:0] r0, r1, r2, r3;

    rst = 1'b1;
    spi_SCLK = 1'b0; spi_MOSI = 1'b0; spi_SS_n = 1'b1;
    status_in = 8'h00; loc_addr = '0; loc_we = 1'b0; loc_wdata = '0;
    abort_byte = 8'h00; col_addr = '0; col_data = '0;
    for (int i = 0; i < 32; i++) mrf[i] = 8'h00;
    for (int i = 0; i < 4; i++) rx_b[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", spi_MISO, 1'b0);
    chk("rst_oe", spi_MISO_oe, 1'b0);
    chk("rst_rdata", loc_rdata, 8'h00);
    chk("rst_stb", spi_wr_stb, 1'b0);
    chk("rst_wr_addr", spi_wr_addr, 5'd0);

    loc_write(5'd4, 8'hC3);

    vt[0] = '{8'hA5, 8'h00, 8'h00, 8'h00, 0, 0, 8'hA5, 8'hA5, 5'd0, 8'h00, 0, 5'd0};
    vt[1] = '{8'h00, 8'h52, 8'h3C, 8'h00, 1, 0, 8'h00, 8'h00, 5'd10, 8'h3C, 1, 5'd10};
    vt[2] = '{8'h00, 8'h20, 8'h00, 8'h00, 1, 0, 8'h00, 8'hC3, 5'd4, 8'hC3, 0, 5'd0};
    vt[3] = '{8'h11, 8'h3A, 8'hFF, 8'h00, 0, 5, 8'h11, 8'h11, 5'd7, 8'h00, 0, 5'd0};
    vt[4] = '{8'h00, 8'hFA, 8'h11, 8'h22, 2, 0, 8'h00, 8'h00, 5'd31,
              (AI ? 8'h11 : 8'h22), 2, (AI ? 5'd0 : 5'd31)};
    vt[5] = '{8'h5A, 8'h50, 8'h00, 8'h00, 2, 0, 8'h5A, (AI ? 8'h00 : 8'h3C), 5'd10, 8'h3C, 0, 5'd0};
    vt[6] = '{8'hC3, 8'hF9, 8'h00, 8'h00, 1, 0, 8'hC3, (AI ? 8'h11 : 8'h22), 5'd31,
              (AI ? 8'h11 : 8'h22), 0, 5'd0};
    vt[7] = '{8'h0F, 8'h2E, 8'h77, 8'h00, 1, 0, 8'h0F, 8'h00, 5'd5, 8'h77, 1, 5'd5};

    for (int v = 0; v < 8; v++) begin
      abort_byte = vt[v].d0;
      s0 = stb_cnt;
      run_xfer(vt[v].status, vt[v].cmd, vt[v].d0, vt[v].d1, 8'h00, vt[v].ndata, vt[v].abort_bits);
      chk($sformatf("vec%0d_miso_b0", v), rx_b[0], vt[v].exp_b0);
      chk($sformatf("vec%0d_miso_last", v), rx_b[nbytes-1], vt[v].exp_last);
      chk($sformatf("vec%0d_stb_cnt", v), stb_cnt - s0, vt[v].exp_stb);
      if (vt[v].exp_stb > 0) chk($sformatf("vec%0d_stb_addr", v), stb_last, vt[v].exp_stb_addr);
      loc_read(vt[v].chk_addr, rd);
      chk($sformatf("vec%0d_reg", v), rd, vt[v].exp_reg);
      $display("[TB] vec %0d cmd=%02h rx0=%02h rxlast=%02h reg[%0d]=%02h", v, vt[v].cmd,
               rx_b[0], rx_b[nbytes-1], vt[v].chk_addr, rd);
    end
    loc_read(5'd0, rd);
    chk("autoinc_wrap_reg0", rd, AI ? 8'h22 : 8'h00);

    // same-address collision: SPI write of 5A against local 99
    col_byte = 1; col_bit = 0; col_addr = 5'd3; col_data = 8'h99;
    s0 = stb_cnt;
    run_xfer(8'h00, 8'h1A, 8'h5A, 8'h00, 8'h00, 1, 0);
    col_byte = -1;
    loc_read(5'd3, rd);
    chk("collide_same_reg3", rd, 8'h5A);
    chk("collide_same_stb", stb_cnt - s0, 1);
    $display("[TB] collide same addr reg3=%02h", rd);

    // different-address collision: both writes commit
    col_byte = 1; col_bit = 0; col_addr = 5'd9; col_data = 8'h99;
    run_xfer(8'h00, 8'h22, 8'h66, 8'h00, 8'h00, 1, 0);
    col_byte = -1;
    mrf[9] = 8'h99;
    loc_read(5'd4, rd);
    chk("collide_diff_reg4", rd, 8'h66);
    loc_read(5'd9, rd);
    chk("collide_diff_reg9", rd, 8'h99);
    $display("[TB] collide diff addr reg4=66 reg9=%02h", rd);

    // read byte in flight is not disturbed by a local write mid-byte
    loc_write(5'd12, 8'h81);
    col_byte = 1; col_bit = 4; col_addr = 5'd12; col_data = 8'h7E;
    run_xfer(8'h00, 8'h60, 8'h00, 8'h00, 8'h00, 1, 0);
    col_byte = -1;
    mrf[12] = 8'h7E;
    chk("inflight_read", rx_b[1], 8'h81);
    loc_read(5'd12, rd);
    chk("inflight_reg12", rd, 8'h7E);
    $display("[TB] inflight read rx=%02h reg12=%02h", rx_b[1], rd);

    // loc_rdata shows a write one cycle after it commits
    @(negedge clk);
    loc_addr = 5'd20; loc_wdata = 8'h4D; loc_we = 1'b1;
    @(negedge clk);
    loc_we = 1'b0;
    chk("rdata_lat_old", loc_rdata, mrf[20]);
    @(negedge clk);
    chk("rdata_lat_new", loc_rdata, 8'h4D);
    mrf[20] = 8'h4D;
    $display("[TB] loc_rdata latency new=%02h", loc_rdata);

    for (int t = 0; t < 30; t++) begin
      int nd, ab;
      if ($urandom_range(1, 0) == 1) loc_write(5'($urandom_range(31, 0)), 8'($urandom));
      nd = $urandom_range(3, 0);
      ab = ($urandom_range(3, 0) == 0) ? $urandom_range(7, 1) : 0;
      abort_byte = 8'($urandom);
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      s0 = stb_cnt;
      run_xfer(r0, r1, r2, r3, 8'($urandom), nd, ab);
      for (int k = 0; k < nbytes; k++) chk($sformatf("rnd%0d_miso%0d", t, k), rx_b[k], exp_rx[k]);
      chk($sformatf("rnd%0d_stb_cnt", t), stb_cnt - s0, exp_stb);
      if (exp_stb > 0) chk($sformatf("rnd%0d_stb_addr", t), stb_last, exp_stb_addr);
      $display("[TB] rnd %0d cmd=%02h nd=%0d abort=%0d rx0=%02h", t, tx_b[0], nd, ab, rx_b[0]);
    end

    for (int a = 0; a < 32; a++) begin
      loc_read(5'(a), rd);
      chk($sformatf("sweep_reg%0d", a), rd, mrf[a]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
